// File: rtl/gaussian_blur_stream_if.sv
// gaussian_blur_stream_if: FIFO-side handshake between the blur stage and its upstream/downstream FIFOs
interface gaussian_blur_stream_if;
   logic       in_empty;
   logic       in_rd_en;
   logic [7:0] in_dout;
   logic       out_full;
   logic       out_wr_en;
   logic [7:0] out_din;
   modport master (input in_empty, in_dout, out_full, output in_rd_en, out_wr_en, out_din);
   modport slave (output in_empty, in_dout, out_full, input in_rd_en, out_wr_en, out_din);
endinterface

// File: rtl/gaussian_blur_stream.sv
// gaussian_blur_stream: streaming 3x3 Gaussian blur from grey FIFO to Sobel FIFO
module gaussian_blur_stream #(
   parameter int WIDTH  = 1920,
   parameter int HEIGHT = 1080
) (
   input logic                    clk,
   input logic                    rst,
   gaussian_blur_stream_if.master bus
);
   localparam int NPIX = WIDTH * HEIGHT;
   localparam int CW   = $clog2(NPIX);
   localparam int XW   = $clog2(WIDTH);
   localparam int YW   = $clog2(HEIGHT);
   typedef enum logic {S_RUN, S_DRAIN} state_t;
   state_t          state, state_nxt;
   logic [CW-1:0]   in_cnt;
   logic [XW-1:0]   in_col, ctr_col;
   logic [YW-1:0]   in_row, ctr_row;
   logic [7:0]      lb1 [WIDTH];
   logic [7:0]      lb2 [WIDTH];
   logic [7:0]      c0 [3];
   logic [7:0]      c1 [3];
   logic [7:0]      nc [3];
   logic            pop, step, emit, last_in, last_out, border;
   logic [11:0]     rs0, rs1, rs2, sum;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_RUN;
      else state <= state_nxt;
   // last pop enters drain, last drained output starts the next frame
   always_comb
      state_nxt = (pop && last_in) ? S_DRAIN : (step && last_out) ? S_RUN : state;
   // handshake: pop in run, drain step in drain, both gated by downstream space
   always_comb begin
      pop          = (state == S_RUN) && !bus.in_empty && !bus.out_full;
      step         = (state == S_DRAIN) && !bus.out_full;
      bus.in_rd_en = pop;
      emit         = step || (pop && in_cnt >= CW'(WIDTH + 1));
   end
   // new window column (zeros while draining) and the weighted kernel sum
   always_comb begin
      last_in  = in_cnt == CW'(NPIX - 1);
      last_out = ctr_row == YW'(HEIGHT - 1) && ctr_col == XW'(WIDTH - 1);
      border   = ctr_row == '0 || ctr_row == YW'(HEIGHT - 1) || ctr_col == '0 || ctr_col == XW'(WIDTH - 1);
      nc[0]    = pop ? lb2[in_col] : 8'd0;
      nc[1]    = pop ? lb1[in_col] : 8'd0;
      nc[2]    = pop ? bus.in_dout : 8'd0;
      rs0      = 12'(c0[0]) + {3'b0, c1[0], 1'b0} + 12'(nc[0]);
      rs1      = 12'(c0[1]) + {3'b0, c1[1], 1'b0} + 12'(nc[1]);
      rs2      = 12'(c0[2]) + {3'b0, c1[2], 1'b0} + 12'(nc[2]);
      sum      = rs0 + {rs1[10:0], 1'b0} + rs2;
   end
   // line buffers: lb1 holds the previous line, lb2 the one before it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            lb1[i] <= 8'd0;
            lb2[i] <= 8'd0;
         end
      end else if (pop) begin
         lb2[in_col] <= lb1[in_col];
         lb1[in_col] <= bus.in_dout;
      end
   // 3x3 window: two stored columns plus the incoming one
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            c0[i] <= 8'd0;
            c1[i] <= 8'd0;
         end
      end else if (pop || step) begin
         c0 <= c1;
         c1 <= nc;
      end
   // input position counters; wrapping on the last pixel clears them for the next frame
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         in_cnt <= '0;
         in_col <= '0;
         in_row <= '0;
      end else if (pop) begin
         in_cnt <= last_in ? '0 : in_cnt + 1'b1;
         in_col <= (in_col == XW'(WIDTH - 1)) ? '0 : in_col + 1'b1;
         if (in_col == XW'(WIDTH - 1)) in_row <= (in_row == YW'(HEIGHT - 1)) ? '0 : in_row + 1'b1;
      end
   // output centre counters; line-edge centres are forced to 0 so lines never mix
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ctr_col       <= '0;
         ctr_row       <= '0;
         bus.out_wr_en <= 1'b0;
         bus.out_din   <= 8'd0;
      end else begin
         bus.out_wr_en <= emit;
         if (emit) begin
            bus.out_din <= border ? 8'd0 : sum[11:4];
            ctr_col     <= (ctr_col == XW'(WIDTH - 1)) ? '0 : ctr_col + 1'b1;
            if (ctr_col == XW'(WIDTH - 1)) ctr_row <= (ctr_row == YW'(HEIGHT - 1)) ? '0 : ctr_row + 1'b1;
         end
      end
endmodule

// File: tb/tb_gaussian_blur_stream.sv
// tb_gaussian_blur_stream: directed 5x5 frames against hand-computed blur results
module tb_gaussian_blur_stream;
   localparam int W = 5;
   localparam int H = 5;
   typedef struct {
      string      name;
      int         kind;
      logic [7:0] val;
      bit         rnd;
      logic [7:0] e_ctr;
      logic [7:0] e_edge;
      logic [7:0] e_corner;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] src[$];
   logic [7:0] got[$];
   bit   rnd_full = 0, rnd_bubble = 0, hold_full = 0, hold_empty = 0;
   logic popped, f1 = 1'b0;
   vec_t vecs[7];
   gaussian_blur_stream_if bus();
   gaussian_blur_stream #(.WIDTH(W), .HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
   // upstream FWFT FIFO and downstream sink model, with the almost-full slack check
   initial begin
      bus.in_empty = 1'b1;
      bus.in_dout  = 8'd0;
      bus.out_full = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.out_wr_en === 1'b1 && !rst) begin
            got.push_back(bus.out_din);
            checks++;
            if (f1) begin
               errors++;
               $display("FAIL overflow: write landed after a pop cycle with out_full=%0b, required 0", f1);
            end
         end
         popped = bus.in_rd_en;
         @(posedge clk);
         #1;
         if (popped === 1'b1 && src.size() > 0) void'(src.pop_front());
         f1 = bus.out_full;
         bus.out_full = hold_full | (rnd_full & ($urandom_range(0, 1) == 1));
         bus.in_empty = hold_empty | (src.size() == 0) | (rnd_bubble & ($urandom_range(0, 1) == 1));
         bus.in_dout  = (src.size() > 0) ? src[0] : 8'd0;
      end
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   function automatic logic [7:0] exp_at(vec_t v, int k);
      int r, c, d;
      r = k / W;
      c = k % W;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
      d = (r > 2 ? r - 2 : 2 - r) + (c > 2 ? c - 2 : 2 - c);
      return d == 0 ? v.e_ctr : d == 1 ? v.e_edge : v.e_corner;
   endfunction
   task automatic push_frame(vec_t v);
      for (int k = 0; k < W * H; k++) src.push_back((v.kind == 0 || k == 12) ? v.val : 8'd0);
   endtask
   task automatic wait_outputs(string name, int n);
      int t = 0;
      while (got.size() < n && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (30) @(posedge clk);
      chk({name, " count"}, got.size(), n);
   endtask
   task automatic check_frame(vec_t v, int base, string tag);
      for (int k = 0; k < W * H; k++)
         chk($sformatf("%s px%0d", tag, k), (base + k < got.size()) ? {24'd0, got[base + k]} : 32'hx, {24'd0, exp_at(v, k)});
   endtask
   initial begin
      vecs[0] = '{"flat100",     0, 8'd100, 1'b0, 8'd100, 8'd100, 8'd100};
      vecs[1] = '{"imp160",      1, 8'd160, 1'b0, 8'd40,  8'd20,  8'd10};
      vecs[2] = '{"flat100_rnd", 0, 8'd100, 1'b1, 8'd100, 8'd100, 8'd100};
      vecs[3] = '{"flat255",     0, 8'd255, 1'b0, 8'd255, 8'd255, 8'd255};
      vecs[4] = '{"imp255",      1, 8'd255, 1'b0, 8'd63,  8'd31,  8'd15};
      vecs[5] = '{"flat7_rnd",   0, 8'd7,   1'b1, 8'd7,   8'd7,   8'd7};
      vecs[6] = '{"imp160_rnd",  1, 8'd160, 1'b1, 8'd40,  8'd20,  8'd10};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset out_wr_en", bus.out_wr_en, 0);
      chk("reset out_din", bus.out_din, 0);
      chk("reset in_rd_en", bus.in_rd_en, 0);
      rst = 1'b0;
      foreach (vecs[i]) begin
         got.delete();
         rnd_full   = vecs[i].rnd;
         rnd_bubble = vecs[i].rnd;
         push_frame(vecs[i]);
         wait_outputs(vecs[i].name, W * H);
         check_frame(vecs[i], 0, vecs[i].name);
         rnd_full   = 0;
         rnd_bubble = 0;
         repeat (3) @(posedge clk);
      end
      got.delete();
      push_frame(vecs[0]);
      push_frame(vecs[1]);
      wait_outputs("b2b", 2 * W * H);
      check_frame(vecs[0], 0, "b2b first");
      check_frame(vecs[1], W * H, "b2b second");
      got.delete();
      hold_full  = 1;
      hold_empty = 1;
      push_frame(vecs[0]);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("hold both rd_en", bus.in_rd_en, 0);
      chk("hold both src", src.size(), W * H);
      chk("hold both writes", got.size(), 0);
      hold_empty = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("hold full rd_en", bus.in_rd_en, 0);
      chk("hold full src", src.size(), W * H);
      hold_full = 0;
      wait_outputs("held", W * H);
      check_frame(vecs[0], 0, "held");
      got.delete();
      for (int k = 0; k < 13; k++) src.push_back(8'd200);
      for (int t = 0; t < 200 && src.size() > 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("partial outputs", got.size(), 7);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midreset out_wr_en", bus.out_wr_en, 0);
      chk("midreset out_din", bus.out_din, 0);
      rst = 1'b0;
      got.delete();
      push_frame(vecs[0]);
      wait_outputs("after reset", W * H);
      check_frame(vecs[0], 0, "after reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
